// File: rtl/dsi_sched_pkg.sv
// Shared types and constants for the DSI packet scheduler.
package dsi_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        EMIT      = 2'd3
    } sched_state_e;

    // Required done flags, bit order {fifo, ecc, crc}
    localparam logic [2:0] REQ_SHORT = 3'b010;
    localparam logic [2:0] REQ_LONG  = 3'b111;

    localparam int unsigned TIMEOUT_DEF = 1024;
    localparam int unsigned DT_W        = 8;
    localparam int unsigned CMD_DATA_W  = 16;

endpackage

// File: rtl/dsi_pkt_scheduler_if.sv
// Requester, engine and serializer signals of the DSI packet scheduler.
interface dsi_pkt_scheduler_if #(
    parameter int unsigned WC_W = 16
);
    import dsi_sched_pkg::*;

    logic                  cmd_req;
    logic [DT_W-1:0]       cmd_dt;
    logic [CMD_DATA_W-1:0] cmd_data;
    logic                  cmd_gnt;
    logic                  vid_req;
    logic [DT_W-1:0]       vid_dt;
    logic [WC_W-1:0]       vid_wc;
    logic                  vid_gnt;
    logic                  eng_start;
    logic                  eng_long;
    logic [DT_W-1:0]       eng_dt;
    logic [WC_W-1:0]       eng_wc;
    logic                  fifo_done;
    logic                  ecc_done;
    logic                  crc_done;
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic                  busy;
    logic                  err_timeout;
    logic                  err_clr;

    modport master (
        input  cmd_req, cmd_dt, cmd_data, vid_req, vid_dt, vid_wc,
               fifo_done, ecc_done, crc_done, pkt_ready, err_clr,
        output cmd_gnt, vid_gnt, eng_start, eng_long, eng_dt, eng_wc,
               pkt_valid, busy, err_timeout
    );

    modport slave (
        output cmd_req, cmd_dt, cmd_data, vid_req, vid_dt, vid_wc,
               fifo_done, ecc_done, crc_done, pkt_ready, err_clr,
        input  cmd_gnt, vid_gnt, eng_start, eng_long, eng_dt, eng_wc,
               pkt_valid, busy, err_timeout
    );

endinterface

// File: rtl/dsi_done_collector.sv
// Sticky engine-done flags, required-mask compare and WAIT_DONE timeout counter.
module dsi_done_collector
    import dsi_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic long_i,
    input  logic fifo_done_i,
    input  logic ecc_done_i,
    input  logic crc_done_i,
    output logic all_done_c,
    output logic timed_out_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]       flags_q, flags_d, seen_c, mask_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A pulse on the completing cycle counts, so compare against flags | inputs
    always_comb begin
        mask_c      = long_i ? REQ_LONG : REQ_SHORT;
        seen_c      = flags_q | {fifo_done_i, ecc_done_i, crc_done_i};
        all_done_c  = en_i && ((seen_c & mask_c) == mask_c);
        timed_out_c = en_i && !all_done_c && (cnt_q == CNT_LAST);
        flags_d     = flags_q;
        cnt_d       = cnt_q;
        if (clr_i) begin
            flags_d = '0;
            cnt_d   = '0;
        end else if (en_i) begin
            flags_d = seen_c;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/dsi_pkt_scheduler.sv
// DSI packet scheduler: cmd/video arbitration, engine sequencing, packet handoff.
// Optional DSI_SCHED_PERF_EN adds per-type transferred-packet counters.
module dsi_pkt_scheduler
    import dsi_sched_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = TIMEOUT_DEF,
    parameter int unsigned WC_W         = 16
) (
    input  logic dsi_clk,
    input  logic dsi_rst,
`ifdef DSI_SCHED_PERF_EN
    output logic [15:0] perf_short_cnt,
    output logic [15:0] perf_long_cnt,
`endif
    dsi_pkt_scheduler_if.master bus
);

    localparam int unsigned SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    sched_state_e    state_q, state_d;
    logic [SC_W-1:0] starve_q, starve_d;
    logic            cmd_gnt_q, cmd_gnt_d, vid_gnt_q, vid_gnt_d;
    logic            eng_start_q, eng_start_d, eng_long_q, eng_long_d;
    logic [DT_W-1:0] eng_dt_q, eng_dt_d;
    logic [WC_W-1:0] eng_wc_q, eng_wc_d;
    logic            pkt_valid_q, pkt_valid_d, busy_q, busy_d, err_q, err_d;
    logic            cmd_wins_c, all_done_c, timed_out_c;

    assign cmd_wins_c = bus.cmd_req &&
                        (!bus.vid_req || (starve_q >= SC_W'(STARVE_LIMIT)));

    dsi_done_collector #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_done (
        .clk         (dsi_clk),
        .rst         (dsi_rst),
        .clr_i       (state_q == START),
        .en_i        (state_q == WAIT_DONE),
        .long_i      (eng_long_q),
        .fifo_done_i (bus.fifo_done),
        .ecc_done_i  (bus.ecc_done),
        .crc_done_i  (bus.crc_done),
        .all_done_c  (all_done_c),
        .timed_out_c (timed_out_c)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        cmd_gnt_d   = 1'b0;
        vid_gnt_d   = 1'b0;
        eng_start_d = 1'b0;
        eng_long_d  = eng_long_q;
        eng_dt_d    = eng_dt_q;
        eng_wc_d    = eng_wc_q;
        pkt_valid_d = pkt_valid_q;
        err_d       = bus.err_clr ? 1'b0 : err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_req || bus.vid_req) begin
                    state_d = START;
                    if (cmd_wins_c) begin
                        cmd_gnt_d  = 1'b1;
                        eng_long_d = 1'b0;
                        eng_dt_d   = bus.cmd_dt;
                        eng_wc_d   = WC_W'(bus.cmd_data);
                        starve_d   = '0;
                    end else begin
                        vid_gnt_d  = 1'b1;
                        eng_long_d = 1'b1;
                        eng_dt_d   = bus.vid_dt;
                        eng_wc_d   = bus.vid_wc;
                        if (bus.cmd_req && (starve_q < SC_W'(STARVE_LIMIT)))
                            starve_d = starve_q + SC_W'(1);
                    end
                end
            end
            START: begin
                eng_start_d = 1'b1;
                state_d     = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (all_done_c) begin
                    state_d     = EMIT;
                    pkt_valid_d = 1'b1;
                end else if (timed_out_c) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            EMIT: begin
                if (bus.pkt_ready) begin
                    state_d     = IDLE;
                    pkt_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge dsi_clk or posedge dsi_rst) begin
        if (dsi_rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            cmd_gnt_q   <= 1'b0;
            vid_gnt_q   <= 1'b0;
            eng_start_q <= 1'b0;
            eng_long_q  <= 1'b0;
            eng_dt_q    <= '0;
            eng_wc_q    <= '0;
            pkt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            cmd_gnt_q   <= cmd_gnt_d;
            vid_gnt_q   <= vid_gnt_d;
            eng_start_q <= eng_start_d;
            eng_long_q  <= eng_long_d;
            eng_dt_q    <= eng_dt_d;
            eng_wc_q    <= eng_wc_d;
            pkt_valid_q <= pkt_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_gnt     = cmd_gnt_q;
    assign bus.vid_gnt     = vid_gnt_q;
    assign bus.eng_start   = eng_start_q;
    assign bus.eng_long    = eng_long_q;
    assign bus.eng_dt      = eng_dt_q;
    assign bus.eng_wc      = eng_wc_q;
    assign bus.pkt_valid   = pkt_valid_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;

`ifdef DSI_SCHED_PERF_EN
    logic [15:0] perf_short_q, perf_long_q;

    // Count on the handshake cycle; wraps naturally
    always_ff @(posedge dsi_clk or posedge dsi_rst) begin
        if (dsi_rst) begin
            perf_short_q <= '0;
            perf_long_q  <= '0;
        end else if ((state_q == EMIT) && bus.pkt_ready) begin
            if (eng_long_q) perf_long_q  <= perf_long_q + 16'd1;
            else            perf_short_q <= perf_short_q + 16'd1;
        end
    end

    assign perf_short_cnt = perf_short_q;
    assign perf_long_cnt  = perf_long_q;
`endif

endmodule

// File: tb/tb_dsi_pkt_scheduler.sv
// Randomized self-checking bench for dsi_pkt_scheduler against a packet-level timeline model.
module tb_dsi_pkt_scheduler;

    localparam int WC_W         = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT_CYC  = 16;

    logic dsi_clk = 1'b0;
    logic dsi_rst;
    always #5 dsi_clk = ~dsi_clk;

    dsi_pkt_scheduler_if #(.WC_W(WC_W)) bus ();

`ifdef DSI_SCHED_PERF_EN
    logic [15:0] perf_short_cnt, perf_long_cnt;
`endif

    dsi_pkt_scheduler #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .WC_W         (WC_W)
    ) dut (
        .dsi_clk        (dsi_clk),
        .dsi_rst        (dsi_rst),
`ifdef DSI_SCHED_PERF_EN
        .perf_short_cnt (perf_short_cnt),
        .perf_long_cnt  (perf_long_cnt),
`endif
        .bus            (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: pending requests, starvation count, sticky error, packet tallies
    bit          cmd_pend, vid_pend, err_m;
    logic [7:0]  cdt, vdt;
    logic [15:0] cdata, vwc;
    int          starve_m, n_short_m, n_long_m;
    int          force_dly[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_dones();
        {bus.fifo_done, bus.ecc_done, bus.crc_done} = 3'b000;
    endtask

    // One IDLE cycle plus, if anything is requested, one full packet.
    // mode: 0 normal, 1 last done on the final allowed cycle, 2 a required done never comes.
    task automatic run_pkt(input int mode, input int new_pct, output int win);
        bit          win_cmd, lng, clr, to_pkt;
        logic [7:0]  e_dt;
        logic [15:0] e_wc;
        logic [2:0]  req, pb;
        int          dly[3];
        int          p, last;
        win = 0;
        if (!cmd_pend && int'($urandom_range(99)) < new_pct) begin
            cmd_pend = 1'b1; cdt = 8'($urandom); cdata = 16'($urandom);
        end
        if (!vid_pend && int'($urandom_range(99)) < new_pct) begin
            vid_pend = 1'b1; vdt = 8'($urandom); vwc = 16'($urandom);
        end
        bus.cmd_req = cmd_pend; bus.cmd_dt = cdt; bus.cmd_data = cdata;
        bus.vid_req = vid_pend; bus.vid_dt = vdt; bus.vid_wc = vwc;
        {bus.fifo_done, bus.ecc_done, bus.crc_done} = 3'($urandom);
        clr = ($urandom_range(3) == 0);
        bus.err_clr = clr;
        @(negedge dsi_clk);
        bus.err_clr = 1'b0;
        if (clr) err_m = 1'b0;
        chk("err_idle", 32'(bus.err_timeout), 32'(err_m));
        if (!cmd_pend && !vid_pend) begin
            chk("no_grant", 32'({bus.cmd_gnt, bus.vid_gnt, bus.busy}), 32'(0));
            clear_dones();
            return;
        end

        win_cmd = cmd_pend && (!vid_pend || starve_m >= STARVE_LIMIT);
        if (win_cmd) starve_m = 0;
        else if (cmd_pend && starve_m < STARVE_LIMIT) starve_m++;
        lng  = !win_cmd;
        e_dt = win_cmd ? cdt : vdt;
        e_wc = win_cmd ? cdata : vwc;
        win  = win_cmd ? 1 : 2;
        chk("cmd_gnt", 32'(bus.cmd_gnt), 32'(win_cmd));
        chk("vid_gnt", 32'(bus.vid_gnt), 32'(!win_cmd));
        chk("busy_start", 32'(bus.busy), 32'(1));
        if (win_cmd) cmd_pend = 1'b0; else vid_pend = 1'b0;
        bus.cmd_req = cmd_pend; bus.vid_req = vid_pend;
        {bus.fifo_done, bus.ecc_done, bus.crc_done} = 3'($urandom);

        @(negedge dsi_clk);
        chk("eng_start", 32'(bus.eng_start), 32'(1));
        chk("eng_long", 32'(bus.eng_long), 32'(lng));
        chk("eng_dt", 32'(bus.eng_dt), 32'(e_dt));
        chk("eng_wc", 32'(bus.eng_wc), 32'(e_wc));
        chk("gnt_pulse", 32'({bus.cmd_gnt, bus.vid_gnt}), 32'(0));

        // Done schedule in WAIT_DONE cycles; index 0 is the eng_start cycle
        req = lng ? 3'b111 : 3'b010;
        for (int i = 0; i < 3; i++)
            dly[i] = (force_dly[i] >= 0) ? force_dly[i] : int'($urandom_range(4));
        p = lng ? int'($urandom_range(2)) : 1;
        if (mode == 1) dly[p] = TIMEOUT_CYC - 1;
        if (mode == 2) dly[p] = -1;
        to_pkt = (mode == 2);
        last = 0;
        for (int i = 0; i < 3; i++)
            if (req[2-i] && dly[i] > last) last = dly[i];

        for (int k = 0; k <= TIMEOUT_CYC; k++) begin
            for (int i = 0; i < 3; i++)
                pb[2-i] = req[2-i] ? (dly[i] == k) : 1'($urandom);
            {bus.fifo_done, bus.ecc_done, bus.crc_done} = pb;
            bus.err_clr = to_pkt && (k == TIMEOUT_CYC - 1) && ($urandom_range(1) != 0);
            @(negedge dsi_clk);
            bus.err_clr = 1'b0;
            clear_dones();
            if (k == 0) chk("eng_start_once", 32'(bus.eng_start), 32'(0));
            if (to_pkt) begin
                if (k == TIMEOUT_CYC - 1) err_m = 1'b1;
                chk("to_valid", 32'(bus.pkt_valid), 32'(0));
                chk("to_busy", 32'(bus.busy), 32'(k < TIMEOUT_CYC - 1));
                chk("to_err", 32'(bus.err_timeout), 32'(err_m));
                if (k == TIMEOUT_CYC - 1) return;
            end else begin
                chk("valid_wait", 32'(bus.pkt_valid), 32'(k >= last));
                chk("busy_wait", 32'(bus.busy), 32'(1));
                if (k >= last) break;
            end
        end

        repeat ($urandom_range(3)) begin
            @(negedge dsi_clk);
            chk("valid_hold", 32'(bus.pkt_valid), 32'(1));
            chk("long_hold", 32'(bus.eng_long), 32'(lng));
        end
        bus.pkt_ready = 1'b1;
        @(negedge dsi_clk);
        bus.pkt_ready = 1'b0;
        chk("valid_drop", 32'(bus.pkt_valid), 32'(0));
        chk("busy_idle", 32'(bus.busy), 32'(0));
        if (lng) n_long_m++; else n_short_m++;
    endtask

    initial begin
        int w;
        bus.cmd_req = 1'b0; bus.cmd_dt = '0; bus.cmd_data = '0;
        bus.vid_req = 1'b0; bus.vid_dt = '0; bus.vid_wc = '0;
        clear_dones();
        bus.pkt_ready = 1'b0; bus.err_clr = 1'b0;
        cmd_pend = 1'b0; vid_pend = 1'b0; err_m = 1'b0;
        starve_m = 0; n_short_m = 0; n_long_m = 0;
        force_dly = '{-1, -1, -1};
        dsi_rst = 1'b1;
        repeat (3) @(negedge dsi_clk);
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_outs", 32'({bus.cmd_gnt, bus.vid_gnt, bus.eng_start, bus.eng_long,
                             bus.pkt_valid, bus.err_timeout}), 32'(0));
        chk("rst_dt_wc", 32'({bus.eng_dt, bus.eng_wc}), 32'(0));
        dsi_rst = 1'b0;
        @(negedge dsi_clk);

        // Short packet, ecc_done three cycles after eng_start
        cmd_pend = 1'b1; cdt = 8'h05; cdata = 16'h1234;
        force_dly = '{-1, 3, -1};
        run_pkt(0, 0, w);
        chk("short_win", 32'(w), 32'(1));

        // Long packets: crc, fifo, ecc on separate cycles; then all on one cycle
        vid_pend = 1'b1; vdt = 8'h39; vwc = 16'h0F00;
        force_dly = '{1, 2, 0};
        run_pkt(0, 0, w);
        vid_pend = 1'b1;
        force_dly = '{2, 2, 2};
        run_pkt(0, 0, w);
        force_dly = '{-1, -1, -1};

        // Both requesters held: V,V,V,V,C repeating
        for (int i = 0; i < 10; i++) begin
            run_pkt(0, 100, w);
            chk("starve_order", 32'(w), 32'((i % 5 == 4) ? 1 : 2));
        end
        while (cmd_pend || vid_pend) run_pkt(0, 0, w);

        // Long packet timeout, then explicit clear
        vid_pend = 1'b1; vdt = 8'h2C; vwc = 16'h0010;
        run_pkt(2, 0, w);
        chk("to_set", 32'(bus.err_timeout), 32'(1));
        bus.err_clr = 1'b1;
        @(negedge dsi_clk);
        bus.err_clr = 1'b0;
        err_m = 1'b0;
        chk("err_clr", 32'(bus.err_timeout), 32'(0));

        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(9));
            run_pkt((r == 0) ? 2 : (r == 1) ? 1 : 0, 70, w);
        end
        while (cmd_pend || vid_pend) run_pkt(0, 0, w);

`ifdef DSI_SCHED_PERF_EN
        chk("perf_short", 32'(perf_short_cnt), 32'(16'(n_short_m)));
        chk("perf_long", 32'(perf_long_cnt), 32'(16'(n_long_m)));
`endif

        // Reset while a long packet waits on crc_done
        bus.vid_req = 1'b1; bus.vid_dt = 8'h2B; bus.vid_wc = 16'h0040;
        @(negedge dsi_clk);
        bus.vid_req = 1'b0;
        chk("rstw_gnt", 32'(bus.vid_gnt), 32'(1));
        @(negedge dsi_clk);
        chk("rstw_start", 32'(bus.eng_start), 32'(1));
        bus.fifo_done = 1'b1; bus.ecc_done = 1'b1;
        @(negedge dsi_clk);
        clear_dones();
        @(negedge dsi_clk);
        chk("rstw_busy", 32'(bus.busy), 32'(1));
        dsi_rst = 1'b1;
        #1;
        chk("rstw_busy0", 32'(bus.busy), 32'(0));
        chk("rstw_valid0", 32'(bus.pkt_valid), 32'(0));
        chk("rstw_outs", 32'({bus.eng_long, bus.err_timeout, bus.eng_wc}), 32'(0));
        @(negedge dsi_clk);
        dsi_rst = 1'b0;
        bus.crc_done = 1'b1;
        @(negedge dsi_clk);
        clear_dones();
        repeat (4) begin
            @(negedge dsi_clk);
            chk("rstw_no_valid", 32'({bus.pkt_valid, bus.busy}), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
